full_gen: RTL and testbench

//  Write-side pointer/flag generator for the dual-clock FIFO; mirror of the read-side empty generator.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/full_gen_gray_to_binary.sv | 17 +
 rtl/full_gen.sv | 61 ++++++
 tb/tb_full_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO.
// The conversions work at 32 bits, so any narrower pointer can be zero-extended into them.
package fifo_pkg;

  function automatic int depth_of(input int size);
    return 1 << (size - 1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/full_gen_gray_to_binary.sv
// Combinational Gray-to-binary conversion (XOR prefix from the MSB down).
module gray_to_binary #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[SIZE-1] = gray[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/full_gen.sv
// Write-side pointer and flag generator for the dual-clock FIFO.
// It synchronises the read Gray pointer and produces the full, almost-full and overflow flags.
module full_gen
  import fifo_pkg::*;
#(
  parameter int SIZE               = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic            write_clock,
  input  logic            reset_n,
  input  logic            write_enable,
  input  logic [SIZE-1:0] read_gray_pointer,
  output logic [SIZE-1:0] write_count,
  output logic [SIZE-1:0] write_gray,
  output logic            write_accept,
  output logic            full_flag,
  output logic            almost_full_flag,
  output logic            overflow_flag
);

  localparam int DEPTH = depth_of(SIZE);
  localparam logic [SIZE-1:0] AF_LEVEL = SIZE'(DEPTH - ALMOST_FULL_MARGIN);

  logic [SIZE-1:0] rsync1, rsync2, rbin;
  logic [SIZE-1:0] wbin_next, wgray_next, level_next, full_gray;

  gray_to_binary #(.SIZE(SIZE)) u_gray_to_binary (
    .gray (rsync2),
    .bin  (rbin)
  );

  always_comb begin
    write_accept = write_enable & ~full_flag;
    wbin_next    = write_count + SIZE'(write_accept);
    wgray_next   = SIZE'(bin2gray(32'(wbin_next)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_gray    = {~rsync2[SIZE-1:SIZE-2], rsync2[SIZE-3:0]};
    level_next   = wbin_next - rbin;
  end

  always_ff @(posedge write_clock) begin
    if (!reset_n) begin
      write_count      <= '0;
      write_gray       <= '0;
      rsync1           <= '0;
      rsync2           <= '0;
      full_flag        <= 1'b0;
      almost_full_flag <= 1'b0;
      overflow_flag    <= 1'b0;
    end else begin
      write_count      <= wbin_next;
      write_gray       <= wgray_next;
      rsync1           <= read_gray_pointer;
      rsync2           <= rsync1;
      full_flag        <= (wgray_next == full_gray);
      almost_full_flag <= (level_next >= AF_LEVEL);
      overflow_flag    <= overflow_flag | (write_enable & full_flag);
    end
  end

endmodule

// File: tb/tb_full_gen.sv
// Directed bench for full_gen: a binary fill-level model pushes the expected state into a
// queue for each step, and the queue is popped and checked after every write_clock edge.
module tb_full_gen;

  logic       write_clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       write_enable = 1'b0;
  logic [3:0] read_gray_pointer = '0;
  logic [3:0] write_count, write_gray;
  logic       write_accept, full_flag, almost_full_flag, overflow_flag;

  full_gen #(.SIZE(4), .ALMOST_FULL_MARGIN(2)) dut (
    .write_clock       (write_clock),
    .reset_n           (reset_n),
    .write_enable      (write_enable),
    .read_gray_pointer (read_gray_pointer),
    .write_count       (write_count),
    .write_gray        (write_gray),
    .write_accept      (write_accept),
    .full_flag         (full_flag),
    .almost_full_flag  (almost_full_flag),
    .overflow_flag     (overflow_flag)
  );

  always #5 write_clock = ~write_clock;

  typedef struct {
    logic [3:0] wc;
    logic [3:0] wg;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: write count, read pointer as seen by the two sync stages (binary), flags
  int   m_wc = 0, m_rs1 = 0, m_rs2 = 0;
  logic m_full = 1'b0, m_af = 1'b0, m_ovf = 1'b0;
  logic [3:0] prev_gray = '0;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic we, input logic rst_n, input int rb);
    exp_t e;
    logic acc;
    int   lvl;
    @(negedge write_clock);
    write_enable = we;
    reset_n = rst_n;
    read_gray_pointer = to_gray(rb);
    #1;
    if (rst_n) begin
      acc = we & ~m_full;
      chk("write_accept", {7'd0, write_accept}, {7'd0, acc});
      m_wc  = (m_wc + int'(acc)) % 16;
      lvl   = (m_wc - m_rs2 + 16) % 16;
      m_ovf = m_ovf | (we & m_full);
      m_full = (lvl == 8);
      m_af  = (lvl >= 6);
      m_rs2 = m_rs1;
      m_rs1 = rb % 16;
    end else begin
      m_wc = 0; m_rs1 = 0; m_rs2 = 0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end
    e.wc = 4'(m_wc);
    e.wg = to_gray(m_wc);
    e.full = m_full;
    e.af = m_af;
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge write_clock);
    #1;
    e = sb.pop_front();
    chk("write_count", {4'd0, write_count}, {4'd0, e.wc});
    chk("write_gray", {4'd0, write_gray}, {4'd0, e.wg});
    chk("full_flag", {7'd0, full_flag}, {7'd0, e.full});
    chk("almost_full_flag", {7'd0, almost_full_flag}, {7'd0, e.af});
    chk("overflow_flag", {7'd0, overflow_flag}, {7'd0, e.ovf});
    if (rst_n)
      chk("gray_one_bit", 8'($countones(write_gray ^ prev_gray) <= 1), 8'd1);
    prev_gray = write_gray;
  endtask

  int tw;

  initial begin
    // Reset with write_enable held high
    step(1'b1, 1'b0, 0);
    chk("rst_count", {4'd0, write_count}, 8'd0);
    chk("rst_flags", {5'd0, full_flag, almost_full_flag, overflow_flag}, 8'd0);

    // Fill eight entries with the read pointer at zero
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 0);
      if (i == 5) chk("af_before_6th", {7'd0, almost_full_flag}, 8'd0);
      if (i == 6) chk("af_on_6th", {7'd0, almost_full_flag}, 8'd1);
      if (i == 7) chk("full_before_8th", {7'd0, full_flag}, 8'd0);
    end
    chk("fill_full", {7'd0, full_flag}, 8'd1);
    chk("fill_count", {4'd0, write_count}, 8'h08);
    chk("fill_gray", {4'd0, write_gray}, 8'h0c);

    // Writes attempted while full
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);
    chk("ovf_count_hold", {4'd0, write_count}, 8'h08);
    step(1'b0, 1'b1, 0);
    chk("ovf_sticky", {7'd0, overflow_flag}, 8'd1);

    // Read pointer jumps to binary 3; the flags release on the third edge
    step(1'b0, 1'b1, 3);
    chk("release_edge1", {7'd0, full_flag}, 8'd1);
    step(1'b0, 1'b1, 3);
    chk("release_edge2", {7'd0, full_flag}, 8'd1);
    step(1'b0, 1'b1, 3);
    chk("release_edge3_full", {7'd0, full_flag}, 8'd0);
    chk("release_edge3_af", {7'd0, almost_full_flag}, 8'd0);

    // Refill to full and overflow again, then reset mid-operation
    repeat (4) step(1'b1, 1'b1, 3);
    chk("refill_full", {7'd0, full_flag}, 8'd1);
    chk("refill_ovf", {7'd0, overflow_flag}, 8'd1);
    step(1'b1, 1'b0, 0);
    chk("midrst_outputs", {write_count, 1'b0, full_flag, almost_full_flag, overflow_flag}, 8'd0);
    step(1'b1, 1'b1, 0);
    chk("first_accept_count", {4'd0, write_count}, 8'h01);
    chk("first_accept_gray", {4'd0, write_gray}, 8'h01);

    // Twenty writes with the reader two entries behind, wrapping the counter
    tw = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, (tw >= 2) ? (tw - 2) % 16 : 0);
      tw++;
    end
    chk("wrap_count", {4'd0, write_count}, 8'h05);
    chk("wrap_no_full", {7'd0, full_flag}, 8'd0);
    chk("wrap_no_ovf", {7'd0, overflow_flag}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
